// File: rtl/hash_target_check_pkg.sv
// Shared types and constants for the hash target checker.
// Optional winner counting is enabled by defining HASH_CHECK_COUNT_EN.
package hash_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] RES_FOUND   = 3'd0;
  localparam logic [2:0] RES_WIN     = 3'd1;
  localparam logic [2:0] RES_MIN     = 3'd2;
  localparam logic [2:0] RES_MIN_IDX = 3'd3;
  localparam logic [2:0] RES_COUNT   = 3'd4;

  localparam logic [31:0] NO_WIN = 32'hFFFFFFFF;

  localparam int RD_LAT = 2;

`ifdef HASH_CHECK_COUNT_EN
  localparam logic [2:0] NUM_WR = 3'd5;
`else
  localparam logic [2:0] NUM_WR = 3'd4;
`endif

endpackage

// File: rtl/hash_target_check_if.sv
// Single-port synchronous memory bus shared with the hashing block.
interface hash_target_check_if;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  modport master (
    output mem_clk,
    output mem_we,
    output mem_addr,
    output mem_write_data,
    input  mem_read_data
  );

  modport slave (
    input  mem_clk,
    input  mem_we,
    input  mem_addr,
    input  mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/hash_target_check_min_tracker.sv
// Registered argmin and first-below-target tracker over a stream of
// indexed 32-bit values; clear restarts tracking.
module hash_min_tracker #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             valid,
  input  logic [31:0]      value,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      target,
  output logic             found,
  output logic [IDX_W-1:0] win_idx,
  output logic [31:0]      min_val,
  output logic [IDX_W-1:0] min_idx
);

  logic have_min;

  // The first valid value always seeds the minimum; later ones replace it
  // only when strictly smaller so ties keep the lower index.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      found    <= 1'b0;
      win_idx  <= '0;
      min_val  <= '0;
      min_idx  <= '0;
      have_min <= 1'b0;
    end else if (valid) begin
      if (!found && (value < target)) begin
        found   <= 1'b1;
        win_idx <= idx;
      end
      if (!have_min || (value < min_val)) begin
        have_min <= 1'b1;
        min_val  <= value;
        min_idx  <= idx;
      end
    end
  end

endmodule

// File: rtl/hash_target_check.sv
// Scans NUM_NONCES hash words from memory against a target and writes a
// result record. HASH_CHECK_COUNT_EN adds a winner count as a fifth word.
module hash_target_check
  import hash_check_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int IDX_W      = $clog2(NUM_NONCES)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  hash_target_check_if.master mem
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  state_t            state_q, state_d;
  logic [31:0]       target_q, target_d;
  logic [15:0]       result_q, result_d;
  logic [IDX_W-1:0]  issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]  smp_idx_q, smp_idx_d;
  logic [RD_LAT-1:0] rd_v_q, rd_v_d;
  logic [2:0]        wr_cnt_q, wr_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              clear, issue, sample;
  logic [31:0]       wr_word;

  logic [IDX_W-1:0]  win_idx, min_idx;
  logic [31:0]       min_val;

  assign sample = rd_v_q[RD_LAT-1];

  hash_min_tracker #(.IDX_W(IDX_W)) u_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .valid   (sample),
    .value   (mem.mem_read_data),
    .idx     (smp_idx_q),
    .target  (target_q),
    .found   (found),
    .win_idx (win_idx),
    .min_val (min_val),
    .min_idx (min_idx)
  );

`ifdef HASH_CHECK_COUNT_EN
  logic [IDX_W:0] win_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      win_cnt_q <= '0;
    end else if (sample && (mem.mem_read_data < target_q)) begin
      win_cnt_q <= win_cnt_q + 1'b1;
    end
  end
`endif

  // Result record word selected by the write counter.
  always_comb begin
    wr_word = '0;
    case (wr_cnt_q)
      RES_FOUND:   wr_word = {31'b0, found};
      RES_WIN:     wr_word = found ? {{(32-IDX_W){1'b0}}, win_idx} : NO_WIN;
      RES_MIN:     wr_word = min_val;
      RES_MIN_IDX: wr_word = {{(32-IDX_W){1'b0}}, min_idx};
`ifdef HASH_CHECK_COUNT_EN
      RES_COUNT:   wr_word = {{(31-IDX_W){1'b0}}, win_cnt_q};
`endif
      default:     wr_word = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    result_d    = result_q;
    issue_idx_d = issue_idx_q;
    smp_idx_d   = sample ? smp_idx_q + 1'b1 : smp_idx_q;
    wr_cnt_d    = wr_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    done_d      = done_q;
    clear       = 1'b0;
    issue       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          target_d    = target;
          result_d    = result_addr;
          done_d      = 1'b0;
          mem_addr_d  = hash_addr;
          issue_idx_d = '0;
          smp_idx_d   = '0;
          wr_cnt_d    = '0;
          clear       = 1'b1;
          issue       = 1'b1;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        issue       = 1'b1;
        mem_addr_d  = mem_addr_q + 16'd1;
        issue_idx_d = issue_idx_q + 1'b1;
        if (issue_idx_d == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (sample && (smp_idx_q == LAST_IDX)) state_d = S_WRITE;
      end
      S_WRITE: begin
        // One extra cycle after the last write lets mem_we fall as done rises.
        if (wr_cnt_q == NUM_WR) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = result_q + {13'b0, wr_cnt_q};
          wdata_d    = wr_word;
          wr_cnt_d   = wr_cnt_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rd_v_d = RD_LAT'({rd_v_q, issue});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      result_q    <= '0;
      issue_idx_q <= '0;
      smp_idx_q   <= '0;
      rd_v_q      <= '0;
      wr_cnt_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      result_q    <= result_d;
      issue_idx_q <= issue_idx_d;
      smp_idx_q   <= smp_idx_d;
      rd_v_q      <= rd_v_d;
      wr_cnt_q    <= wr_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
    end
  end

  assign done               = done_q;
  assign mem.mem_clk        = clk;
  assign mem.mem_we         = mem_we_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_write_data = wdata_q;

endmodule
